// File: rtl/pipeline_mem_stage7.sv
// Memory-access stage: aligned loads/stores over a req/ready port with lane
// steering, sign/zero extension and a stall while a transaction is in flight.
module pipeline_mem_stage7 (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [63:0] pc_EXA,
  input  logic [63:0] alu_result_EXA,
  input  logic [63:0] reg_data2_EXA,
  input  logic [4:0]  rd_EXA,
  input  logic        rf_wr_en_EXA,
  input  logic [1:0]  rf_wr_sel_EXA,
  input  logic [2:0]  dm_rd_ctrl_EXA,
  input  logic [2:0]  dm_wr_ctrl_EXA,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  output logic [7:0]  dm_wstrb,
  input  logic        dm_ready,
  input  logic [63:0] dm_rdata,
  output logic        mem_stall,
  output logic [63:0] pc_MEM,
  output logic [63:0] alu_result_MEM,
  output logic [63:0] load_data_MEM,
  output logic [4:0]  rd_MEM,
  output logic        rf_wr_en_MEM,
  output logic [1:0]  rf_wr_sel_MEM,
  output logic        misalign_MEM,
  output logic [1:0]  fsm_state_o
);

  // Handshake: dm_req stays high with stable fields until the cycle dm_ready
  // is sampled high; that same cycle carries dm_rdata for loads.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_e;

  state_e state_q, state_d;

  logic        is_load, is_store, is_op, misaligned, aligned_op;
  logic [1:0]  size_log2;
  logic [2:0]  off, align_mask;
  logic [7:0]  size_mask;

  logic        launch, out_en, out_bubble, out_misalign, out_use_cap;

  logic [63:0] addr_q, wdata_q, cap_q;
  logic [7:0]  wstrb_q;
  logic        we_q;
  logic [2:0]  ld_type_q, off_q;

  logic [63:0] pc_q, alu_q, ld_q;
  logic [4:0]  rd_q;
  logic        wr_en_q, misalign_q;
  logic [1:0]  wr_sel_q;

  logic [63:0] rd_shift, ld_ext;

  // Decode the incoming instruction; a load wins over a store field.
  always_comb begin
    is_load   = (dm_rd_ctrl_EXA != 3'd0);
    is_store  = !is_load && (dm_wr_ctrl_EXA >= 3'd1) && (dm_wr_ctrl_EXA <= 3'd4);
    is_op     = is_load || is_store;
    off       = alu_result_EXA[2:0];
    size_log2 = 2'd0;
    if (is_load) begin
      case (dm_rd_ctrl_EXA)
        3'd1, 3'd2: size_log2 = 2'd0;
        3'd3, 3'd4: size_log2 = 2'd1;
        3'd5, 3'd6: size_log2 = 2'd2;
        default:    size_log2 = 2'd3;
      endcase
    end else if (is_store) begin
      size_log2 = 2'(dm_wr_ctrl_EXA - 3'd1);
    end
    case (size_log2)
      2'd0:    begin align_mask = 3'b000; size_mask = 8'h01; end
      2'd1:    begin align_mask = 3'b001; size_mask = 8'h03; end
      2'd2:    begin align_mask = 3'b011; size_mask = 8'h0F; end
      default: begin align_mask = 3'b111; size_mask = 8'hFF; end
    endcase
    misaligned = is_op && ((off & align_mask) != 3'd0);
    aligned_op = is_op && !misaligned;
  end

  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    out_en       = 1'b0;
    out_bubble   = 1'b0;
    out_misalign = 1'b0;
    out_use_cap  = 1'b0;
    case (state_q)
      S_IDLE: begin
        out_en = !stall;
        if (aligned_op) begin
          launch     = 1'b1;
          out_bubble = 1'b1;
          state_d    = S_REQ;
        end else begin
          out_misalign = misaligned;
        end
      end
      S_REQ: begin
        if (dm_ready) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall) begin
          out_en      = 1'b1;
          out_use_cap = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request fields are only written on launch, so they hold through REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= 64'd0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
      we_q      <= 1'b0;
      ld_type_q <= 3'd0;
      off_q     <= 3'd0;
    end else if (launch) begin
      addr_q    <= {alu_result_EXA[63:3], 3'b000};
      wdata_q   <= is_store ? (reg_data2_EXA << {off, 3'b000}) : 64'd0;
      wstrb_q   <= is_store ? (size_mask << off) : 8'd0;
      we_q      <= is_store;
      ld_type_q <= is_load ? dm_rd_ctrl_EXA : 3'd0;
      off_q     <= off;
    end
  end

  always_comb begin
    rd_shift = dm_rdata >> {off_q, 3'b000};
    case (ld_type_q)
      3'd1:    ld_ext = {{56{rd_shift[7]}}, rd_shift[7:0]};
      3'd2:    ld_ext = {56'd0, rd_shift[7:0]};
      3'd3:    ld_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    ld_ext = {48'd0, rd_shift[15:0]};
      3'd5:    ld_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'd6:    ld_ext = {32'd0, rd_shift[31:0]};
      3'd7:    ld_ext = rd_shift;
      default: ld_ext = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          cap_q <= 64'd0;
    else if (state_q == S_REQ && dm_ready) cap_q <= ld_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= 64'd0;
      alu_q      <= 64'd0;
      ld_q       <= 64'd0;
      rd_q       <= 5'd0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 2'd0;
      misalign_q <= 1'b0;
    end else if (out_en) begin
      pc_q       <= pc_EXA;
      alu_q      <= alu_result_EXA;
      ld_q       <= out_use_cap ? cap_q : 64'd0;
      rd_q       <= out_bubble ? 5'd0 : rd_EXA;
      wr_en_q    <= (out_bubble || out_misalign) ? 1'b0 : rf_wr_en_EXA;
      wr_sel_q   <= rf_wr_sel_EXA;
      misalign_q <= out_misalign;
    end
  end

  assign dm_req    = (state_q == S_REQ);
  assign dm_we     = dm_req & we_q;
  assign dm_addr   = dm_req ? addr_q  : 64'd0;
  assign dm_wdata  = dm_req ? wdata_q : 64'd0;
  assign dm_wstrb  = dm_req ? wstrb_q : 8'd0;
  assign mem_stall = ((state_q == S_IDLE) && aligned_op) || (state_q == S_REQ);

  assign pc_MEM         = pc_q;
  assign alu_result_MEM = alu_q;
  assign load_data_MEM  = ld_q;
  assign rd_MEM         = rd_q;
  assign rf_wr_en_MEM   = wr_en_q;
  assign rf_wr_sel_MEM  = wr_sel_q;
  assign misalign_MEM   = misalign_q;
  assign fsm_state_o    = state_q;

endmodule

// File: tb/tb_pipeline_mem_stage7.sv
// Directed bench for pipeline_mem_stage7: non-ops, loads, stores, misalignment,
// delayed ready, stall in DONE and reset during a request.
module tb_pipeline_mem_stage7;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [63:0] pc_EXA, alu_result_EXA, reg_data2_EXA;
  logic [4:0]  rd_EXA;
  logic        rf_wr_en_EXA;
  logic [1:0]  rf_wr_sel_EXA;
  logic [2:0]  dm_rd_ctrl_EXA, dm_wr_ctrl_EXA;
  logic        dm_req, dm_we, dm_ready, mem_stall;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [7:0]  dm_wstrb;
  logic [63:0] pc_MEM, alu_result_MEM, load_data_MEM;
  logic [4:0]  rd_MEM;
  logic        rf_wr_en_MEM, misalign_MEM;
  logic [1:0]  rf_wr_sel_MEM, fsm_state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  always #5 clk = ~clk;

  pipeline_mem_stage7 dut (
    .clk(clk), .reset(reset), .stall(stall),
    .pc_EXA(pc_EXA), .alu_result_EXA(alu_result_EXA), .reg_data2_EXA(reg_data2_EXA),
    .rd_EXA(rd_EXA), .rf_wr_en_EXA(rf_wr_en_EXA), .rf_wr_sel_EXA(rf_wr_sel_EXA),
    .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA), .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall),
    .pc_MEM(pc_MEM), .alu_result_MEM(alu_result_MEM), .load_data_MEM(load_data_MEM),
    .rd_MEM(rd_MEM), .rf_wr_en_MEM(rf_wr_en_MEM), .rf_wr_sel_MEM(rf_wr_sel_MEM),
    .misalign_MEM(misalign_MEM), .fsm_state_o(fsm_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    pc_EXA = 64'h0; alu_result_EXA = 64'h0; reg_data2_EXA = 64'h0;
    rd_EXA = 5'd0; rf_wr_en_EXA = 1'b0; rf_wr_sel_EXA = 2'd0;
    dm_rd_ctrl_EXA = 3'd0; dm_wr_ctrl_EXA = 3'd0;
  endtask

  // One aligned memory op: IDLE cycle, (waits+1) REQ cycles, DONE held for
  // stall_cyc cycles, then the write-back registers are checked.
  task automatic mem_op(input string tag, input logic [2:0] rdc, input logic [2:0] wrc,
                        input logic [63:0] addr, input logic [63:0] data2,
                        input logic [63:0] rdata, input int waits, input int stall_cyc,
                        input logic [4:0] rd, input logic wen,
                        input logic [63:0] exp_ld, input logic [7:0] exp_strb,
                        input logic [63:0] exp_wdata);
    pc_EXA = 64'h400 + addr; alu_result_EXA = addr; reg_data2_EXA = data2;
    rd_EXA = rd; rf_wr_en_EXA = wen; rf_wr_sel_EXA = 2'd1;
    dm_rd_ctrl_EXA = rdc; dm_wr_ctrl_EXA = wrc;
    dm_rdata = rdata; dm_ready = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, 64'(mem_stall), 64'd1);
    chk({tag, "_idle_req"}, 64'(dm_req), 64'd0);
    for (int i = 0; i <= waits; i++) begin
      step();
      chk({tag, "_req"}, 64'(dm_req), 64'd1);
      chk({tag, "_addr"}, dm_addr, {addr[63:3], 3'b000});
      chk({tag, "_we"}, 64'(dm_we), 64'(wrc != 3'd0 && rdc == 3'd0));
      chk({tag, "_wstrb"}, 64'(dm_wstrb), 64'(exp_strb));
      chk({tag, "_wdata"}, dm_wdata, exp_wdata);
      chk({tag, "_req_stall"}, 64'(mem_stall), 64'd1);
      dm_ready = (i == waits);
    end
    step();
    dm_ready = 1'b0;
    dm_rdata = ~rdata;
    chk({tag, "_done_state"}, 64'(fsm_state_o), 64'(ST_DONE));
    chk({tag, "_done_stall"}, 64'(mem_stall), 64'd0);
    chk({tag, "_done_req"}, 64'(dm_req), 64'd0);
    chk({tag, "_bubble_wen"}, 64'(rf_wr_en_MEM), 64'd0);
    chk({tag, "_bubble_rd"}, 64'(rd_MEM), 64'd0);
    for (int i = 0; i < stall_cyc; i++) begin
      stall = 1'b1;
      dm_ready = 1'b1;
      step();
      chk({tag, "_park_state"}, 64'(fsm_state_o), 64'(ST_DONE));
      chk({tag, "_park_hold"}, 64'(rd_MEM), 64'd0);
    end
    stall = 1'b0;
    dm_ready = 1'b0;
    step();
    chk({tag, "_ld"}, load_data_MEM, exp_ld);
    chk({tag, "_rd"}, 64'(rd_MEM), 64'(rd));
    chk({tag, "_wen"}, 64'(rf_wr_en_MEM), 64'(wen));
    chk({tag, "_alu"}, alu_result_MEM, addr);
    chk({tag, "_misalign"}, 64'(misalign_MEM), 64'd0);
    chk({tag, "_idle"}, 64'(fsm_state_o), 64'(ST_IDLE));
    set_nop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; dm_ready = 1'b0; dm_rdata = 64'h0;
    set_nop();
    #3;
    chk("rst_state", 64'(fsm_state_o), 64'(ST_IDLE));
    chk("rst_req", 64'(dm_req), 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_alu", alu_result_MEM, 64'd0);
    chk("rst_ld", load_data_MEM, 64'd0);
    chk("rst_wstrb", 64'(dm_wstrb), 64'd0);
    #9;
    reset = 1'b1;

    // Non-op passes through in one cycle
    alu_result_EXA = 64'h1234; rd_EXA = 5'd5; rf_wr_en_EXA = 1'b1; pc_EXA = 64'h100;
    rf_wr_sel_EXA = 2'd2;
    #1;
    chk("nop_stall", 64'(mem_stall), 64'd0);
    step();
    chk("nop_alu", alu_result_MEM, 64'h1234);
    chk("nop_rd", 64'(rd_MEM), 64'd5);
    chk("nop_wen", 64'(rf_wr_en_MEM), 64'd1);
    chk("nop_pc", pc_MEM, 64'h100);
    chk("nop_sel", 64'(rf_wr_sel_MEM), 64'd2);
    chk("nop_ld", load_data_MEM, 64'd0);
    chk("nop_stall2", 64'(mem_stall), 64'd0);

    // Global stall freezes the output registers
    stall = 1'b1; alu_result_EXA = 64'h5555; rd_EXA = 5'd6;
    step();
    chk("frz_alu", alu_result_MEM, 64'h1234);
    chk("frz_rd", 64'(rd_MEM), 64'd5);
    stall = 1'b0;
    set_nop();

    mem_op("lb", 3'd1, 3'd0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0,
           5'd7, 1'b1, 64'hFFFFFFFF_FFFFFF80, 8'h00, 64'h0);
    mem_op("lbu", 3'd2, 3'd0, 64'h1003, 64'h0, 64'h00000000_80000000, 0, 0,
           5'd8, 1'b1, 64'h80, 8'h00, 64'h0);
    mem_op("lw", 3'd5, 3'd0, 64'h3004, 64'h0, 64'h80000001_00000000, 1, 0,
           5'd10, 1'b1, 64'hFFFFFFFF_80000001, 8'h00, 64'h0);
    mem_op("lhu", 3'd4, 3'd0, 64'h3006, 64'h0, 64'hF00D_0000_0000_0000, 0, 0,
           5'd11, 1'b1, 64'hF00D, 8'h00, 64'h0);
    mem_op("sh", 3'd0, 3'd2, 64'h2006, 64'hABCD, 64'h0, 0, 0,
           5'd0, 1'b0, 64'h0, 8'hC0, 64'hABCD0000_00000000);
    mem_op("sb", 3'd0, 3'd1, 64'h2001, 64'h5A, 64'h0, 0, 0,
           5'd0, 1'b0, 64'h0, 8'h02, 64'h5A00);
    mem_op("sd", 3'd0, 3'd4, 64'h6000, 64'h11223344_55667788, 64'h0, 2, 0,
           5'd0, 1'b0, 64'h0, 8'hFF, 64'h11223344_55667788);
    mem_op("ld", 3'd7, 3'd0, 64'h4008, 64'h0, 64'h01234567_89ABCDEF, 4, 2,
           5'd12, 1'b1, 64'h01234567_89ABCDEF, 8'h00, 64'h0);

    // Misaligned LW is suppressed and retires in one cycle
    alu_result_EXA = 64'h3002; dm_rd_ctrl_EXA = 3'd5; rd_EXA = 5'd9; rf_wr_en_EXA = 1'b1;
    #1;
    chk("mis_stall", 64'(mem_stall), 64'd0);
    chk("mis_req", 64'(dm_req), 64'd0);
    step();
    chk("mis_flag", 64'(misalign_MEM), 64'd1);
    chk("mis_wen", 64'(rf_wr_en_MEM), 64'd0);
    chk("mis_rd", 64'(rd_MEM), 64'd9);
    chk("mis_alu", alu_result_MEM, 64'h3002);
    chk("mis_req2", 64'(dm_req), 64'd0);
    set_nop();
    step();
    chk("mis_clear", 64'(misalign_MEM), 64'd0);

    // Reset during REQ aborts at once
    alu_result_EXA = 64'h5000; dm_rd_ctrl_EXA = 3'd7; rd_EXA = 5'd3; rf_wr_en_EXA = 1'b1;
    step();
    chk("ab_req", 64'(dm_req), 64'd1);
    set_nop();
    reset = 1'b0;
    #1;
    chk("ab_req0", 64'(dm_req), 64'd0);
    chk("ab_addr", dm_addr, 64'd0);
    chk("ab_state", 64'(fsm_state_o), 64'(ST_IDLE));
    chk("ab_stall", 64'(mem_stall), 64'd0);
    chk("ab_alu", alu_result_MEM, 64'd0);
    chk("ab_pc", pc_MEM, 64'd0);
    chk("ab_ld", load_data_MEM, 64'd0);
    #2;
    reset = 1'b1;
    alu_result_EXA = 64'h77; rd_EXA = 5'd4; rf_wr_en_EXA = 1'b1;
    step();
    chk("post_alu", alu_result_MEM, 64'h77);
    chk("post_rd", 64'(rd_MEM), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
